// File: rtl/seg7_mmio_display.sv
// rtl/seg7_mmio_display.sv - MMIO LED register consumer driving an 8-digit multiplexed 7-segment display
//
// Captures 32-bit values written to the LED register and scans them as eight hex
// digits on a common-anode display. New values take effect only on a scan-frame
// boundary, so one frame never mixes digits from two different values.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   led_wdata    value from the LED register write
//   led_we       one-cycle write strobe, qualifies led_wdata
//   an           digit anodes, active-low, bit i = digit i (digit 0 = nibble [3:0])
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low, always off
//   frame_tick   one-cycle pulse when the scan wraps from the last digit to digit 0
//   shown_value  value currently being scanned
module seg7_mmio_display #(
   parameter int unsigned REFRESH_DIV     = 100000,
   parameter int unsigned NUM_DIGITS      = 8,
   parameter bit          LEAD_ZERO_BLANK = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] led_wdata,
   input  logic        led_we,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick,
   output logic [31:0] shown_value
);

   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
   logic [31:0]      pending_val_q, pending_val_d;
   logic             pending_q, pending_d;
   logic [31:0]      shown_q, shown_d;
   logic             tick_q, tick_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;

   logic             terminal;
   logic             boundary;
   logic [31:0]      upper;
   logic             blank;

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      case (nib)
         4'h0: hex_decode = 7'h40;
         4'h1: hex_decode = 7'h79;
         4'h2: hex_decode = 7'h24;
         4'h3: hex_decode = 7'h30;
         4'h4: hex_decode = 7'h19;
         4'h5: hex_decode = 7'h12;
         4'h6: hex_decode = 7'h02;
         4'h7: hex_decode = 7'h78;
         4'h8: hex_decode = 7'h00;
         4'h9: hex_decode = 7'h10;
         4'hA: hex_decode = 7'h08;
         4'hB: hex_decode = 7'h03;
         4'hC: hex_decode = 7'h46;
         4'hD: hex_decode = 7'h21;
         4'hE: hex_decode = 7'h06;
         default: hex_decode = 7'h0E;
      endcase
   endfunction

   always_comb begin
      terminal = (div_cnt_q == DIV_LAST);
      boundary = terminal && (digit_idx_q == IDX_LAST);

      div_cnt_d   = terminal ? '0 : div_cnt_q + 1'b1;
      digit_idx_d = terminal ? digit_idx_q + 1'b1 : digit_idx_q;

      // Last write in a frame wins; the pending flag survives until a boundary.
      pending_val_d = led_we ? led_wdata : pending_val_q;
      pending_d     = pending_q | led_we;
      shown_d       = shown_q;
      if (boundary) begin
         // A write landing on the boundary edge itself bypasses the pending
         // register so it is not deferred a whole extra frame.
         if (led_we) begin
            shown_d   = led_wdata;
            pending_d = 1'b0;
         end else if (pending_q) begin
            shown_d   = pending_val_q;
            pending_d = 1'b0;
         end
      end
      tick_d = boundary;

      // upper holds the current digit and everything above it; zero means this
      // slot is a leading zero. Digit 0 is never blanked.
      upper = shown_q >> {digit_idx_q, 2'b00};
      blank = LEAD_ZERO_BLANK && (digit_idx_q != '0) && (upper == 32'h0);
      an_d  = blank ? 8'hFF : ~(8'h01 << digit_idx_q);
      seg_d = blank ? 7'h7F : hex_decode(upper[3:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         digit_idx_q   <= '0;
         pending_val_q <= 32'h0;
         pending_q     <= 1'b0;
         shown_q       <= 32'h0;
         tick_q        <= 1'b0;
         an_q          <= 8'hFF;
         seg_q         <= 7'h7F;
      end else begin
         div_cnt_q     <= div_cnt_d;
         digit_idx_q   <= digit_idx_d;
         pending_val_q <= pending_val_d;
         pending_q     <= pending_d;
         shown_q       <= shown_d;
         tick_q        <= tick_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = 1'b1;
   assign frame_tick  = tick_q;
   assign shown_value = shown_q;

endmodule

// File: tb/tb_seg7_mmio_display.sv
// tb/tb_seg7_mmio_display.sv - directed vector bench for seg7_mmio_display
module tb_seg7_mmio_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] led_wdata = 32'h0;
   logic        led_we = 1'b0;

   logic [7:0]  an, an_nb;
   logic [6:0]  seg, seg_nb;
   logic        dp, dp_nb;
   logic        frame_tick, frame_tick_nb;
   logic [31:0] shown_value, shown_value_nb;

   seg7_mmio_display #(.REFRESH_DIV(4), .NUM_DIGITS(8), .LEAD_ZERO_BLANK(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .led_wdata(led_wdata), .led_we(led_we),
      .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick), .shown_value(shown_value)
   );

   seg7_mmio_display #(.REFRESH_DIV(4), .NUM_DIGITS(8), .LEAD_ZERO_BLANK(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .led_wdata(led_wdata), .led_we(led_we),
      .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame_tick(frame_tick_nb),
      .shown_value(shown_value_nb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] val;
      logic [63:0] an_exp;   // {digit7 .. digit0}
      logic [55:0] seg_exp;  // {digit7 .. digit0}
   } vec_t;

   localparam logic [63:0] AN_ALL = 64'h7FBFDFEFF7FBFDFE;

   vec_t        vecs[7];
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] cap_an, cap_an_nb;
   logic [55:0] cap_seg, cap_seg_nb;
   logic [31:0] prev;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 100);
      chk("frame_tick_seen", n, 32'(frame_tick), 32'h1);
   endtask

   // Called right after frame_tick is sampled; samples each digit slot mid-way.
   task automatic capture();
      for (int d = 0; d < 8; d++) begin
         repeat ((d == 0) ? 2 : 4) @(negedge clk);
         cap_an[8*d +: 8]     = an;
         cap_seg[7*d +: 7]    = seg;
         cap_an_nb[8*d +: 8]  = an_nb;
         cap_seg_nb[7*d +: 7] = seg_nb;
      end
   endtask

   task automatic chk_frame(input string nm, input logic [63:0] a, input logic [63:0] ea,
                            input logic [55:0] s, input logic [55:0] es);
      for (int d = 0; d < 8; d++) begin
         chk({nm, "_an"}, d, 32'(a[8*d +: 8]), 32'(ea[8*d +: 8]));
         chk({nm, "_seg"}, d, 32'(s[7*d +: 7]), 32'(es[7*d +: 7]));
      end
   endtask

   task automatic write(input logic [31:0] v);
      led_wdata = v;
      led_we    = 1'b1;
      @(negedge clk);
      led_we    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;

      vecs[0] = '{32'h12345678, AN_ALL,
                  {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
      vecs[1] = '{32'h9ABCDEF0, AN_ALL,
                  {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}};
      vecs[2] = '{32'h000A0000, 64'hFFFFFFEFF7FBFDFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40}};
      vecs[3] = '{32'h80000000, AN_ALL,
                  {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
      vecs[4] = '{32'h00000005, 64'hFFFFFFFFFFFFFFFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12}};
      vecs[5] = '{32'hFFFFFFFF, AN_ALL,
                  {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};
      vecs[6] = '{32'h00000010, 64'hFFFFFFFFFFFFFDFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}};

      // Held in reset
      repeat (3) @(negedge clk);
      chk("rst_an", 0, 32'(an), 32'hFF);
      chk("rst_seg", 0, 32'(seg), 32'h7F);
      chk("rst_dp", 0, 32'(dp), 32'h1);
      chk("rst_tick", 0, 32'(frame_tick), 32'h0);
      chk("rst_shown", 0, shown_value, 32'h0);
      rst_n = 1'b1;

      // Idle frame shows a single 0 on digit 0, and the tick period is 32
      wait_tick();
      chk("idle_shown", 0, shown_value, 32'h0);
      capture();
      chk_frame("idle", cap_an, 64'hFFFFFFFFFFFFFFFE, cap_seg,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      wait_tick();
      @(negedge clk);
      chk("tick_width", 0, 32'(frame_tick), 32'h0);
      cnt = 1;
      while (!frame_tick && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("tick_period", 0, cnt, 32);

      // Table: write mid-frame, value held until the next boundary
      prev = 32'h0;
      foreach (vecs[i]) begin
         wait_tick();
         repeat (5) @(negedge clk);
         write(vecs[i].val);
         chk("hold_until_tick", i, shown_value, prev);
         wait_tick();
         chk("shown_at_tick", i, shown_value, vecs[i].val);
         capture();
         chk_frame($sformatf("vec%0d", i), cap_an, vecs[i].an_exp, cap_seg, vecs[i].seg_exp);
         prev = vecs[i].val;
      end

      // Two writes in one frame: last one wins
      wait_tick();
      repeat (3) @(negedge clk);
      write(32'h0000AAAA);
      repeat (2) @(negedge clk);
      write(32'h0000BEEF);
      chk("dbl_hold", 0, shown_value, 32'h00000010);
      wait_tick();
      chk("dbl_shown", 0, shown_value, 32'h0000BEEF);
      capture();
      chk_frame("dbl", cap_an, 64'hFFFFFFFFF7FBFDFE, cap_seg,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E});

      // Write on the exact boundary edge bypasses pending
      wait_tick();
      repeat (31) @(negedge clk);
      chk("byp_before", 0, shown_value, 32'h0000BEEF);
      write(32'hCAFEF00D);
      chk("byp_tick", 0, 32'(frame_tick), 32'h1);
      chk("byp_shown", 0, shown_value, 32'hCAFEF00D);
      wait_tick();
      chk("byp_no_reapply", 0, shown_value, 32'hCAFEF00D);

      // No blanking: 0x5 lights all eight digits
      repeat (4) @(negedge clk);
      write(32'h00000005);
      wait_tick();
      chk("nb_shown", 0, shown_value_nb, 32'h00000005);
      capture();
      chk_frame("nb", cap_an_nb, AN_ALL, cap_seg_nb,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12});
      chk("nb_dp", 0, 32'(dp_nb), 32'h1);

      // Asynchronous reset mid-scan discards a pending write
      wait_tick();
      write(32'h11111111);
      wait_tick();
      repeat (9) @(negedge clk);
      chk("pre_rst_an_lit", 0, 32'(an == 8'hFF), 32'h0);
      write(32'h22222222);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_an", 0, 32'(an), 32'hFF);
      chk("async_seg", 0, 32'(seg), 32'h7F);
      chk("async_shown", 0, shown_value, 32'h0);
      chk("async_tick", 0, 32'(frame_tick), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_tick();
      chk("post_rst_shown", 0, shown_value, 32'h0);
      capture();
      chk_frame("post_rst", cap_an, 64'hFFFFFFFFFFFFFFFE, cap_seg,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      wait_tick();
      chk("post_rst_lost", 0, shown_value, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
